// File: rtl/stdp_sweep_scheduler.sv
// Sweep sequencer for the 16-synapse STDP learning datapath: issues mux selects, delayed
// weight write-backs, INIT sweeps, and queues start/init triggers that arrive while busy.
module stdp_sweep_scheduler #(
  parameter int NUM_SYN       = 16,
  parameter int IDX_W         = 4,
  parameter int PIPE_LAT      = 2,
  parameter int WEIGHT_W      = 4,
  parameter int INIT_WEIGHT   = 2,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                init_req,
  input  logic                learn_en,
  output logic [IDX_W-1:0]    sel,
  output logic                sel_valid,
  output logic                wr_en,
  output logic [IDX_W-1:0]    wr_addr,
  output logic                wr_init,
  output logic [WEIGHT_W-1:0] init_data,
  output logic                busy,
  output logic                done,
  output logic                pending,
  output logic [7:0]          drop_cnt,
  output logic [15:0]         sweep_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_SWEEP, S_DRAIN, S_FINISH} state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_SYN - 1);

  state_t           state_q;
  logic             boot_q;
  logic             learn_q;
  logic             init_pend_q, init_pend_d;
  logic             pending_q, pending_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;
  logic [15:0]      sweep_cnt_q;
  logic [IDX_W-1:0] sel_q, wr_addr_q;
  logic             sel_valid_q, wr_en_q, wr_init_q, busy_q, done_q;
  logic [PIPE_LAT-1:0] pipe_vld_q;
  logic [IDX_W-1:0]    pipe_sel_q [PIPE_LAT];
  logic             go_init, go_sweep, queue_en;

  // Launch decisions are only taken from IDLE or FINISH; INIT always outranks a learning sweep.
  always_comb begin
    go_init  = 1'b0;
    go_sweep = 1'b0;
    if (state_q == S_IDLE) begin
      go_init  = boot_q | init_pend_q | init_req;
      go_sweep = ~go_init & (pending_q | start);
    end else if (state_q == S_FINISH) begin
      go_init  = init_pend_q;
      go_sweep = ~init_pend_q & pending_q;
    end
  end

  // A start that does not itself launch a sweep is queued; a second one while queued is dropped.
  always_comb begin
    queue_en    = (state_q != S_IDLE) | go_init;
    init_pend_d = init_pend_q;
    pending_d   = pending_q;
    drop_cnt_d  = drop_cnt_q;
    if (queue_en && init_req) init_pend_d = 1'b1;
    if (go_init)              init_pend_d = 1'b0;
    if (go_sweep)             pending_d   = 1'b0;
    if (queue_en && start) begin
      if (!pending_d)                pending_d  = 1'b1;
      else if (drop_cnt_q != 8'hFF)  drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      boot_q      <= (INIT_ON_RESET != 0);
      learn_q     <= 1'b0;
      init_pend_q <= 1'b0;
      pending_q   <= 1'b0;
      drop_cnt_q  <= '0;
      sweep_cnt_q <= '0;
      sel_q       <= '0;
      sel_valid_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_init_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pipe_vld_q  <= '0;
      for (int i = 0; i < PIPE_LAT; i++) pipe_sel_q[i] <= '0;
    end else begin
      boot_q      <= 1'b0;
      init_pend_q <= init_pend_d;
      pending_q   <= pending_d;
      drop_cnt_q  <= drop_cnt_d;
      done_q      <= 1'b0;
      sel_valid_q <= 1'b0;
      wr_en_q     <= 1'b0;
      for (int i = PIPE_LAT - 1; i > 0; i--) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_sel_q[i] <= pipe_sel_q[i-1];
      end
      pipe_vld_q[0] <= 1'b0;

      // Write-back side: the oldest delay-line slot becomes this cycle's write strobe.
      if (state_q == S_SWEEP || state_q == S_DRAIN) begin
        wr_en_q <= pipe_vld_q[PIPE_LAT-1] & learn_q;
        if (pipe_vld_q[PIPE_LAT-1]) wr_addr_q <= pipe_sel_q[PIPE_LAT-1];
      end

      case (state_q)
        S_IDLE, S_FINISH: begin
          if (go_init) begin
            state_q   <= S_INIT;
            busy_q    <= 1'b1;
            wr_en_q   <= 1'b1;
            wr_init_q <= 1'b1;
            wr_addr_q <= '0;
          end else if (go_sweep) begin
            state_q       <= S_SWEEP;
            busy_q        <= 1'b1;
            wr_init_q     <= 1'b0;
            learn_q       <= learn_en;
            sel_q         <= '0;
            sel_valid_q   <= 1'b1;
            pipe_vld_q[0] <= 1'b1;
            pipe_sel_q[0] <= '0;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_INIT: begin
          if (wr_addr_q == LAST) begin
            state_q   <= S_FINISH;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            wr_init_q <= 1'b0;
          end else begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= wr_addr_q + IDX_W'(1);
          end
        end
        S_SWEEP: begin
          if (sel_q == LAST) begin
            state_q <= S_DRAIN;
          end else begin
            sel_q         <= sel_q + IDX_W'(1);
            sel_valid_q   <= 1'b1;
            pipe_vld_q[0] <= 1'b1;
            pipe_sel_q[0] <= sel_q + IDX_W'(1);
          end
        end
        S_DRAIN: begin
          if (pipe_vld_q == '0) begin
            state_q     <= S_FINISH;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            sweep_cnt_q <= sweep_cnt_q + 16'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sel       = sel_q;
  assign sel_valid = sel_valid_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_init   = wr_init_q;
  assign init_data = WEIGHT_W'(INIT_WEIGHT);
  assign busy      = busy_q;
  assign done      = done_q;
  assign pending   = pending_q;
  assign drop_cnt  = drop_cnt_q;
  assign sweep_cnt = sweep_cnt_q;

endmodule
